// File: rtl/ddr_rd_responder_pkg.sv
// Shared widths, request descriptor and engine state encoding for the DDR read responder.
package ddr_rd_responder_pkg;

   localparam int DDR_W      = 64;
   localparam int DDR_ADDR_W = 32;
   localparam int BURST_W    = 8;

   // Bit width needed to index n entries (at least 1).
   function automatic int bw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef struct packed {
      logic [DDR_ADDR_W-1:0] addr;
      logic [BURST_W-1:0]    size;
   } ddr_req_t;

   typedef enum logic [0:0] {
      ENG_IDLE  = 1'b0,
      ENG_BURST = 1'b1
   } eng_state_e;

endpackage

// File: rtl/ddr_rsp_fifo.sv
// Generic synchronous FIFO with show-ahead read data; DEPTH must be a power of 2.
module ddr_rsp_fifo
   import ddr_rd_responder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        push,
   input  logic [WIDTH-1:0]            wr_data,
   input  logic                        pop,
   output logic [WIDTH-1:0]            rd_data,
   output logic                        empty,
   output logic [bw(DEPTH+1)-1:0]      count
);

   localparam int PTR_W = bw(DEPTH);
   localparam int CNT_W = bw(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   // Pushes into a full FIFO and pops from an empty one are dropped.
   assign do_push = push && (count_q != CNT_W'(DEPTH));
   assign do_pop  = pop && (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign empty   = (count_q == '0);
   assign count   = count_q;

endmodule

// File: rtl/ddr_rd_responder.sv
// DDR read-port responder: queues burst requests and streams beats from a preloadable memory.
// Optional out-of-range checking is enabled by defining DDR_RD_RSP_RANGE_CHK_EN.
module ddr_rd_responder
   import ddr_rd_responder_pkg::*;
#(
   parameter int MEM_DEPTH = 4096,
   parameter int REQ_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DDR_ADDR_W-1:0]      addr,
   input  logic [BURST_W-1:0]         size,
   input  logic                       addr_valid,
   output logic                       addr_ready,
   output logic [DDR_W-1:0]           data,
   output logic                       valid,
   input  logic                       ready,
   input  logic                       pl_wr_en,
   input  logic [bw(MEM_DEPTH)-1:0]   pl_wr_addr,
   input  logic [DDR_W-1:0]           pl_wr_data,
   output logic                       busy,
   output logic                       err,
   output eng_state_e                 dbg_state
);

   localparam int IDX_W     = bw(MEM_DEPTH);
   localparam int REQ_CNT_W = bw(REQ_DEPTH + 1);
   localparam int OB_CNT_W  = bw(3);

   eng_state_e              state_q, state_d;
   logic [DDR_ADDR_W-1:0]   cur_addr_q, cur_addr_d;
   logic [BURST_W-1:0]      beats_left_q, beats_left_d;
   logic                    rd_vld_q, rd_vld_d;
   logic                    rdy_en_q, rdy_en_d;

   logic                    req_accept;
   ddr_req_t                req_in, rq_head;
   logic                    rq_empty, rq_pop;
   logic [REQ_CNT_W-1:0]    rq_count;

   logic                    ob_push, ob_pop, ob_empty;
   logic [DDR_W-1:0]        ob_head;
   logic [OB_CNT_W-1:0]     ob_count;
   logic [OB_CNT_W:0]       occ;

   logic                    rd_en, last_issue;
   logic [IDX_W-1:0]        rd_idx;
   logic [DDR_W-1:0]        ram_q, rd_word;
   logic [DDR_W-1:0]        mem [MEM_DEPTH];

   // addr_ready is held low until the first clock after reset release.
   assign addr_ready = rdy_en_q && (rq_count != REQ_CNT_W'(REQ_DEPTH));
   assign req_accept = addr_valid && addr_ready;
   assign req_in     = '{addr: addr, size: size};

   ddr_rsp_fifo #(.WIDTH($bits(ddr_req_t)), .DEPTH(REQ_DEPTH)) u_req_q (
      .clk     (clk),
      .rst_n   (rst),
      .push    (req_accept),
      .wr_data (req_in),
      .pop     (rq_pop),
      .rd_data (rq_head),
      .empty   (rq_empty),
      .count   (rq_count)
   );

   // Engine state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ENG_IDLE;
         cur_addr_q   <= '0;
         beats_left_q <= '0;
         rd_vld_q     <= 1'b0;
         rdy_en_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_addr_q   <= cur_addr_d;
         beats_left_q <= beats_left_d;
         rd_vld_q     <= rd_vld_d;
         rdy_en_q     <= rdy_en_d;
      end
   end

   // Engine next state: a pop on the last issue reloads in the same cycle, so bursts chain without a bubble.
   always_comb begin
      state_d      = state_q;
      cur_addr_d   = cur_addr_q;
      beats_left_d = beats_left_q;
      if (rd_en) begin
         cur_addr_d   = cur_addr_q + DDR_ADDR_W'(1);
         beats_left_d = beats_left_q - BURST_W'(1);
         if (last_issue) state_d = ENG_IDLE;
      end
      if (rq_pop && (rq_head.size != '0)) begin
         state_d      = ENG_BURST;
         cur_addr_d   = rq_head.addr;
         beats_left_d = rq_head.size;
      end
   end

   // Engine outputs: credit counts beats buffered plus the read in flight against the 2-entry buffer.
   always_comb begin
      occ        = {1'b0, ob_count} + {{OB_CNT_W{1'b0}}, rd_vld_q};
      rd_en      = (state_q == ENG_BURST) && (occ < (OB_CNT_W+1)'(2));
      last_issue = rd_en && (beats_left_q == BURST_W'(1));
      rq_pop     = !rq_empty && ((state_q == ENG_IDLE) || last_issue);
      rd_idx     = IDX_W'(cur_addr_q % DDR_ADDR_W'(MEM_DEPTH));
      rd_vld_d   = rd_en;
      rdy_en_d   = 1'b1;
   end

   // Read-first BRAM: a same-cycle preload write to the read address returns the old word.
   always_ff @(posedge clk) begin
      if (pl_wr_en) mem[pl_wr_addr] <= pl_wr_data;
      if (rd_en)    ram_q <= mem[rd_idx];
   end

`ifdef DDR_RD_RSP_RANGE_CHK_EN
   logic rd_oob_q, rd_oob_d;
   logic err_q, err_d;
   logic issue_oob;

   always_comb begin
      issue_oob = cur_addr_q >= DDR_ADDR_W'(MEM_DEPTH);
      rd_oob_d  = rd_en && issue_oob;
      err_d     = err_q || (rd_en && issue_oob);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_oob_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         rd_oob_q <= rd_oob_d;
         err_q    <= err_d;
      end
   end

   assign rd_word = rd_oob_q ? '0 : ram_q;
   assign err     = err_q;
`else
   assign rd_word = ram_q;
   assign err     = 1'b0;
`endif

   // The returning read bypasses the buffer when it is empty and the beat is taken; otherwise it queues behind it.
   always_comb begin
      ob_push = rd_vld_q && !(ob_empty && ready);
      ob_pop  = !ob_empty && ready;
      valid   = !ob_empty || rd_vld_q;
      data    = !ob_empty ? ob_head : (rd_vld_q ? rd_word : '0);
      busy    = (rq_count != '0) || (state_q == ENG_BURST) || rd_vld_q || !ob_empty;
   end

   ddr_rsp_fifo #(.WIDTH(DDR_W), .DEPTH(2)) u_out_buf (
      .clk     (clk),
      .rst_n   (rst),
      .push    (ob_push),
      .wr_data (rd_word),
      .pop     (ob_pop),
      .rd_data (ob_head),
      .empty   (ob_empty),
      .count   (ob_count)
   );

   assign dbg_state = state_q;

endmodule

// File: tb/tb_ddr_rd_responder.sv
// Directed bench for ddr_rd_responder: latency, chaining, back-pressure, queue full, size 0, reset, wrap/range.
module tb_ddr_rd_responder;
   import ddr_rd_responder_pkg::*;

   localparam int MEM_DEPTH = 4096;
   localparam int REQ_DEPTH = 4;
   localparam int IDX_W     = bw(MEM_DEPTH);

   logic                  clk = 1'b0;
   logic                  rst;
   logic [DDR_ADDR_W-1:0] addr;
   logic [BURST_W-1:0]    size;
   logic                  addr_valid;
   logic                  addr_ready;
   logic [DDR_W-1:0]      data;
   logic                  valid;
   logic                  ready;
   logic                  pl_wr_en;
   logic [IDX_W-1:0]      pl_wr_addr;
   logic [DDR_W-1:0]      pl_wr_data;
   logic                  busy;
   logic                  err;
   eng_state_e            dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   logic [DDR_W-1:0] exp_q[$];

   ddr_rd_responder #(.MEM_DEPTH(MEM_DEPTH), .REQ_DEPTH(REQ_DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .size       (size),
      .addr_valid (addr_valid),
      .addr_ready (addr_ready),
      .data       (data),
      .valid      (valid),
      .ready      (ready),
      .pl_wr_en   (pl_wr_en),
      .pl_wr_addr (pl_wr_addr),
      .pl_wr_data (pl_wr_data),
      .busy       (busy),
      .err        (err),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [DDR_W-1:0] mval(input int i);
      return {32'hC0DE_0000, 32'(i)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input int a, input int s);
      int w = 0;
      while (!addr_ready && w < 20) begin
         step();
         w++;
      end
      chk("req_ready", 64'(addr_ready), 64'd1);
      addr       = DDR_ADDR_W'(a);
      size       = BURST_W'(s);
      addr_valid = 1'b1;
      step();
      addr_valid = 1'b0;
   endtask

   // mode 0: ready held high; mode 1: ready follows 1,0,0,1 repeating.
   task automatic drain(input int mode, input int budget, output bit seen_ardy);
      int         cyc     = 0;
      bit         stalled = 1'b0;
      logic [DDR_W-1:0] held = '0;
      bit         pat[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
      seen_ardy = 1'b0;
      while (exp_q.size() != 0 && cyc < budget) begin
         ready = (mode == 1) ? pat[cyc % 4] : 1'b1;
         if (addr_ready) seen_ardy = 1'b1;
         if (stalled) begin
            chk("stall_valid", 64'(valid), 64'd1);
            chk("stall_data", data, held);
         end
         if (valid && ready) chk("beat_data", data, exp_q.pop_front());
         stalled = valid && !ready;
         held    = data;
         step();
         cyc++;
      end
      chk("drain_left", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      ready = 1'b1;
   endtask

   initial begin
      int  t2[7] = '{16, 17, 18, 19, 40, 41, 42};
      int  acc;
      bit  seen;

      rst        = 1'b0;
      addr       = '0;
      size       = '0;
      addr_valid = 1'b0;
      ready      = 1'b1;
      pl_wr_en   = 1'b0;
      pl_wr_addr = '0;
      pl_wr_data = '0;

      // Reset state
      #12;
      chk("rst_addr_ready", 64'(addr_ready), 64'd0);
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_data", data, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      rst = 1'b1;
      step();
      chk("post_rst_addr_ready", 64'(addr_ready), 64'd1);
      chk("post_rst_state", 64'(dbg_state), 64'(ENG_IDLE));

      // Preload
      for (int i = 0; i < 64; i++) begin
         pl_wr_en = 1'b1; pl_wr_addr = IDX_W'(i); pl_wr_data = mval(i);
         step();
      end
      pl_wr_en = 1'b1; pl_wr_addr = IDX_W'(4094); pl_wr_data = mval(4094); step();
      pl_wr_en = 1'b1; pl_wr_addr = IDX_W'(4095); pl_wr_data = mval(4095); step();
      pl_wr_en = 1'b0;

      // Single burst, exact latency
      send_req(0, 8);
      chk("lat_t1_valid", 64'(valid), 64'd0);
      chk("lat_t1_busy", 64'(busy), 64'd1);
      step();
      chk("lat_t2_valid", 64'(valid), 64'd0);
      step();
      for (int i = 0; i < 8; i++) begin
         chk("b1_valid", 64'(valid), 64'd1);
         chk("b1_data", data, mval(i));
         step();
      end
      chk("b1_end_valid", 64'(valid), 64'd0);
      chk("b1_end_busy", 64'(busy), 64'd0);

      // Back-to-back bursts, no gap
      send_req(16, 4);
      send_req(40, 3);
      step();
      for (int i = 0; i < 7; i++) begin
         chk("b2b_valid", 64'(valid), 64'd1);
         chk("b2b_data", data, mval(t2[i]));
         step();
      end
      chk("b2b_end_valid", 64'(valid), 64'd0);

      // Same requests under toggling ready
      send_req(16, 4);
      send_req(40, 3);
      for (int i = 0; i < 7; i++) exp_q.push_back(mval(t2[i]));
      drain(1, 80, seen);
      chk("tog_end_busy", 64'(busy), 64'd0);
      step();
      chk("tog_no_extra", 64'(valid), 64'd0);

      // Queue fills with ready held low
      ready = 1'b0;
      acc   = 0;
      for (int k = 0; k < 8; k++) begin
         if (!addr_ready) break;
         addr = DDR_ADDR_W'(2 * acc); size = BURST_W'(2); addr_valid = 1'b1;
         step();
         addr_valid = 1'b0;
         acc++;
      end
      chk("full_accepts", 64'(acc), 64'(REQ_DEPTH + 2));
      for (int k = 0; k < 3; k++) begin
         chk("full_addr_ready", 64'(addr_ready), 64'd0);
         chk("full_hold_data", data, mval(0));
         step();
      end
      for (int i = 0; i < 12; i++) exp_q.push_back(mval(i));
      drain(0, 80, seen);
      chk("full_recover", 64'(seen), 64'd1);
      chk("full_end_busy", 64'(busy), 64'd0);

      // Zero-size request between two bursts
      send_req(20, 2);
      send_req(30, 0);
      send_req(50, 2);
      exp_q.push_back(mval(20)); exp_q.push_back(mval(21));
      exp_q.push_back(mval(50)); exp_q.push_back(mval(51));
      drain(0, 40, seen);
      chk("sz0_end_busy", 64'(busy), 64'd0);
      for (int k = 0; k < 3; k++) begin
         chk("sz0_no_extra", 64'(valid), 64'd0);
         step();
      end

      // Reset mid-burst
      send_req(0, 8);
      for (int k = 0; k < 5; k++) step();
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(valid), 64'd0);
      chk("mid_rst_data", data, 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_addr_ready", 64'(addr_ready), 64'd0);
      step();
      step();
      rst = 1'b1;
      step();
      chk("rel_addr_ready", 64'(addr_ready), 64'd1);
      chk("rel_valid", 64'(valid), 64'd0);
      send_req(8, 3);
      exp_q.push_back(mval(8)); exp_q.push_back(mval(9)); exp_q.push_back(mval(10));
      drain(0, 40, seen);
      chk("rst_rerun_busy", 64'(busy), 64'd0);
      chk("pre_range_err", 64'(err), 64'd0);

      // Burst crossing the top of memory
      send_req(MEM_DEPTH - 2, 4);
      exp_q.push_back(mval(4094));
      exp_q.push_back(mval(4095));
`ifdef DDR_RD_RSP_RANGE_CHK_EN
      exp_q.push_back(64'd0);
      exp_q.push_back(64'd0);
`else
      exp_q.push_back(mval(0));
      exp_q.push_back(mval(1));
`endif
      drain(0, 40, seen);
`ifdef DDR_RD_RSP_RANGE_CHK_EN
      chk("range_err", 64'(err), 64'd1);
`else
      chk("range_err", 64'(err), 64'd0);
`endif
      chk("range_end_busy", 64'(busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
